// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    REQ   = 2'd0,  // request outstanding at PC
    HOLD  = 2'd1,  // word parked while IF/ID is stalled, no request
    DRAIN = 2'd2   // redirected; waiting out a stale response
  } fetch_state_t;

  // Contents of a pipeline register between IF and ID.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Bubble value: no instruction, PC+4 cleared.
  function automatic ifid_t make_bubble(input logic [31:0] nop_word);
    ifid_t b;
    b.instr = nop_word;
    b.pc4   = 32'd0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// Pipeline register with flush > stall > load priority and async reset
// to the bubble value.
module ifid_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic  CLOCK,
  input  logic  RESET,
  input  logic  FLUSH,
  input  logic  STALL,
  input  ifid_t LOAD_DATA,
  output ifid_t REG_DATA
);

  // Flush wins over stall, stall wins over load.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      REG_DATA <= make_bubble(BUBBLE_INSTR);
    end else if (FLUSH) begin
      REG_DATA <= make_bubble(BUBBLE_INSTR);
    end else if (!STALL) begin
      REG_DATA <= LOAD_DATA;
    end
  end

endmodule

// File: rtl/ifid_fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory handshake, holding
// buffer for stalled returns, redirect handling and the IF/ID register.
//
// IMEM handshake: a word transfers on every rising edge where IMEM_REQ and
// IMEM_READY are both high. READY may already be high in the first cycle
// of a request. While IMEM_REQ is high and READY is low, IMEM_ADDR is held.
module ifid_fetch_stage #(
  parameter logic [31:0] RESET_PC  = mips_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       STALL_IFID,
  input  logic                       FLUSH_IFID,
  input  logic                       BRANCH_TAKEN,
  input  logic [31:0]                BRANCH_TARGET,
  output logic                       IMEM_REQ,
  output logic [31:0]                IMEM_ADDR,
  input  logic                       IMEM_READY,
  input  logic [31:0]                IMEM_RDATA,
  output logic [31:0]                INSTR_IFID,
  output logic [31:0]                PC4_IFID,
  output logic                       VALID_IFID,
  output logic [5:0]                 Opcode_IFID,
  output logic [5:0]                 Funcode_IFID,
  output logic                       FETCH_BUSY,
  output mips_pipe_pkg::fetch_state_t FETCH_STATE
);

  import mips_pipe_pkg::fetch_state_t;
  import mips_pipe_pkg::ifid_t;
  import mips_pipe_pkg::make_bubble;
  import mips_pipe_pkg::REQ;
  import mips_pipe_pkg::HOLD;
  import mips_pipe_pkg::DRAIN;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [31:0]  hold_word;
  logic         hold_valid;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_pc;
  logic [31:0]  reset_pc_aligned;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  assign pc_plus4         = pc + 32'd4;
  assign target_pc        = BRANCH_TARGET & ~32'h3;
  assign reset_pc_aligned = RESET_PC & ~32'h3;

  // Request drops with reset asynchronously; no request while parked.
  assign IMEM_REQ    = RESET & (state != HOLD);
  assign IMEM_ADDR   = (state == DRAIN) ? drain_addr : pc;
  assign FETCH_BUSY  = IMEM_REQ & ~IMEM_READY;
  assign FETCH_STATE = state;

  // Candidate IF/ID contents; a redirect or a missing word gives a bubble.
  always_comb begin
    ifid_d = make_bubble(NOP_INSTR);
    if (!BRANCH_TAKEN) begin
      case (state)
        REQ: begin
          if (IMEM_READY) begin
            ifid_d.instr = IMEM_RDATA;
            ifid_d.pc4   = pc_plus4;
            ifid_d.valid = 1'b1;
          end
        end
        HOLD: begin
          ifid_d.instr = hold_word;
          ifid_d.pc4   = pc_plus4;
          ifid_d.valid = hold_valid;
        end
        default: ifid_d = make_bubble(NOP_INSTR);
      endcase
    end
  end

  // Fetch sequencer: PC, holding buffer and redirect draining.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= REQ;
      pc         <= reset_pc_aligned;
      drain_addr <= reset_pc_aligned;
      hold_word  <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      // Redirect moves the PC even while IF/ID is stalled.
      pc         <= target_pc;
      hold_valid <= 1'b0;
      case (state)
        REQ: begin
          drain_addr <= pc;
          state      <= IMEM_READY ? REQ : DRAIN;
        end
        HOLD:    state <= REQ;
        DRAIN:   state <= DRAIN;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (IMEM_READY) begin
            if (STALL_IFID) begin
              hold_word  <= IMEM_RDATA;
              hold_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!STALL_IFID) begin
            pc         <= pc_plus4;
            hold_valid <= 1'b0;
            state      <= REQ;
          end
        end
        DRAIN: begin
          if (IMEM_READY) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  ifid_pipe_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .FLUSH     (FLUSH_IFID),
    .STALL     (STALL_IFID),
    .LOAD_DATA (ifid_d),
    .REG_DATA  (ifid_q)
  );

  assign INSTR_IFID   = ifid_q.instr;
  assign PC4_IFID     = ifid_q.pc4;
  assign VALID_IFID   = ifid_q.valid;
  assign Opcode_IFID  = ifid_q.instr[31:26];
  assign Funcode_IFID = ifid_q.instr[5:0];

endmodule

// File: doc/ifid_fetch_stage.md
Name: ifid_fetch_stage

Overview:
- Consumer end of the hazard unit's IF/ID stall/flush interface.
- Owns the PC and drives a request/ready handshake to instruction memory, with a variable number of wait cycles.
- Holds the IF/ID pipeline register and returns FETCH_BUSY to the hazard unit.
- Handles redirects from the branch unit in ID and discards any fetch that is in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush or bubble (sll $0,$0,0).

Ports:
- CLOCK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-low.
- STALL_IFID  in  1  hazard unit: hold the IF/ID register and the PC.
- FLUSH_IFID  in  1  hazard unit: load a bubble into IF/ID.
- BRANCH_TAKEN  in  1  redirect request from ID.
- BRANCH_TARGET  in  32  redirect PC; word-aligned, bits[1:0] ignored.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address; stable while IMEM_REQ=1.
- IMEM_READY  in  1  IMEM_RDATA valid; may be high in the same cycle as IMEM_REQ.
- IMEM_RDATA  in  32  fetched word.
- INSTR_IFID  out  32  IF/ID instruction.
- PC4_IFID  out  32  PC+4 of INSTR_IFID.
- VALID_IFID  out  1  INSTR_IFID is a real instruction.
- Opcode_IFID  out  6  INSTR_IFID[31:26].
- Funcode_IFID  out  6  INSTR_IFID[5:0].
- FETCH_BUSY  out  1  IMEM_REQ & !IMEM_READY.

Behaviour:
- Reset (async, RESET=0):
  - PC=RESET_PC, state=REQ.
  - INSTR_IFID=NOP_INSTR, PC4_IFID=0, VALID_IFID=0, holding buffer empty.
  - IMEM_REQ=0 while in reset; it is 1 in the first cycle after release.
- States:
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC.
  - HOLD: IMEM_REQ=0; fetched word parked in the holding buffer.
  - DRAIN: IMEM_REQ=1, old address; the response will be discarded.
- REQ, IMEM_READY=1, no redirect:
  - STALL_IFID=0: IF/ID loads {RDATA, PC+4, VALID=1}; PC<=PC+4; stay in REQ. Throughput is 1 instruction/cycle on zero-wait memory.
  - STALL_IFID=1: RDATA is captured into the holding buffer; go to HOLD.
- REQ, IMEM_READY=0, STALL_IFID=0: IF/ID loads a bubble {NOP_INSTR, VALID=0}. The request is held with the same address.
- HOLD: when STALL_IFID=0, IF/ID loads the buffer, PC<=PC+4, go to REQ. Latency from stall release to the instruction appearing in IF/ID is 1 cycle.
- BRANCH_TAKEN=1:
  - PC<=BRANCH_TARGET; the holding buffer is cleared.
  - Redirect overrides STALL_IFID for the PC only; IF/ID obeys stall/flush.
  - REQ with READY=0: go to DRAIN.
  - REQ with READY=1, or HOLD: the word is dropped; go to REQ.
- DRAIN: wait for IMEM_READY, drop the data, then go to REQ at the new PC. A second BRANCH_TAKEN while in DRAIN overwrites PC and stays in DRAIN.
- IF/ID update priority: FLUSH_IFID > STALL_IFID > load.
  - FLUSH sets INSTR=NOP_INSTR and VALID=0 even while stalled.
  - FLUSH does not alter PC or state unless BRANCH_TAKEN is also asserted.
- Opcode_IFID/Funcode_IFID are combinational slices of INSTR_IFID.
- PC+4 wraps modulo 2^32. PC[1:0] is forced to 0.
- Reset asserted mid-handshake: state is abandoned immediately and IMEM_REQ drops asynchronously.
- Assertions:
  - IMEM_ADDR must not change while IMEM_REQ=1 && IMEM_READY=0.
  - VALID_IFID=1 implies INSTR_IFID came from IMEM_RDATA.

Decomposition:
- Package mips_pipe_pkg holds:
  - fetch_state_t enum {REQ, HOLD, DRAIN};
  - NOP_INSTR, RESET_PC constants;
  - ifid_t struct {instr, pc4, valid}.
- One sub-module, ifid_pipe_reg:
  - ifid_t register with flush > stall > load priority and async reset to the bubble value;
  - reused later for ID/EX.

Test Plan:
- Zero-wait memory (READY tied 1), no stalls, after reset → IMEM_ADDR 0,4,8,… on consecutive cycles. IF/ID shows RDATA with PC4 = addr+4 and VALID=1 one cycle later.
- 3-wait-cycle memory → FETCH_BUSY=1 for 3 cycles. IMEM_ADDR stays stable, IF/ID gets 3 bubbles (VALID=0), then the instruction.
- STALL_IFID=1 for 4 cycles while the word at 0x10 returns → IMEM_REQ=0 in HOLD and IF/ID unchanged. 1 cycle after release, INSTR_IFID = word@0x10 and the next IMEM_ADDR=0x14.
- BRANCH_TAKEN with target 0x100 while fetch of 0x20 is pending (READY after 2 cycles) → state DRAIN and the 0x20 data is never VALID. The next request is IMEM_ADDR=0x100.
- FLUSH_IFID and STALL_IFID high together → INSTR_IFID=NOP_INSTR, VALID_IFID=0, PC unchanged.
- RESET pulled low mid-wait at PC 0x40 → outputs reach reset values asynchronously. After release, the first IMEM_ADDR is RESET_PC.
